// File: rtl/inst_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_loader_pkg
//  Description : Shared definitions for the instruction-memory program
//                loader: loader state encoding, word packing size and the
//                default address width, which follows the processor PC width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_loader_pkg;

    // Processor PC width in words; instruction memory is addressed with it.
    localparam int PC_WIDTH            = 10;
    localparam int DEFAULT_ADDR_WIDTH  = PC_WIDTH;
    localparam int DEFAULT_COUNT_WIDTH = 16;

    // Bytes packed into one instruction word.
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHECK  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } loader_state_t;

    // States in which the loader takes a byte from the stream.
    function automatic logic accepts_bytes(input loader_state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
               (s == ST_DATA)   || (s == ST_CHECK);
    endfunction

    // The processor is released only when idle or after a good load;
    // ERROR keeps it frozen so partially loaded code never runs.
    function automatic logic holds_cpu(input loader_state_t s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_loader_if
//  Description : Byte-stream (valid/ready) and instruction-memory write bus
//                of the program loader.
//  Ports       : byte_valid, byte_data  - stream source to loader
//                byte_ready             - loader to stream source
//                mem_we, mem_addr, mem_wdata - loader to instruction memory
//  Modports    : slave  - the loader's view
//                master - the environment's view (source + memory)
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_mem_loader_if
    import mips_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_loader
//  Description : Loads a program into instruction memory from a byte stream.
//                Stream: COUNT (hi, lo), COUNT words MSB first, XOR checksum
//                of all preceding bytes. Words are written to consecutive
//                word addresses from 0 while the processor is held.
//  Ports       : clock, reset_n (async, active low), start
//                bus      - stream in / memory write out (slave modport)
//                cpu_hold - freezes processor PC and register writes
//                done     - last load completed with a good checksum
//                error    - last load failed (checksum or count overflow)
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader
    import mips_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    inst_mem_loader_if.slave       bus,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error
);

    localparam int          c_idx_w     = $clog2(WORD_BYTES);
    // One extra bit so COUNT == 2^ADDR_WIDTH can be counted without wrapping.
    localparam int          c_acc_w     = ADDR_WIDTH + 1;
    localparam int unsigned c_max_words = 2 ** ADDR_WIDTH;

    loader_state_t          r_state;
    loader_state_t          w_next;
    logic [7:0]             r_len_hi;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [c_acc_w-1:0]     r_addr;
    logic [c_idx_w-1:0]     r_idx;
    logic [31:0]            r_shift;
    logic [7:0]             r_csum;
    logic                   r_byte_ready;
    logic                   r_mem_we;
    logic                   r_cpu_hold;
    logic                   r_done;
    logic                   r_error;

    logic                   w_xfer;
    logic [COUNT_WIDTH-1:0] w_count_rx;
    logic                   w_overflow;
    logic                   w_last_byte;
    logic                   w_last_word;

    // byte_ready is a register, so the handshake has no combinational
    // path from byte_valid back to byte_ready.
    assign w_xfer      = bus.byte_valid & r_byte_ready;
    assign w_count_rx  = COUNT_WIDTH'({r_len_hi, bus.byte_data});
    assign w_overflow  = 32'(w_count_rx) > c_max_words;
    assign w_last_byte = (r_idx == c_idx_w'(WORD_BYTES - 1));
    // Evaluated in WRITE, before the address increments.
    assign w_last_word = (32'(r_addr) + 32'd1) == 32'(r_count);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    w_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (w_xfer) begin
                    w_next = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_xfer) begin
                    if (w_count_rx == '0) begin
                        w_next = ST_CHECK;
                    end else if (w_overflow) begin
                        w_next = ST_ERROR;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_xfer && w_last_byte) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_next = w_last_word ? ST_CHECK : ST_DATA;
            end
            ST_CHECK: begin
                if (w_xfer) begin
                    w_next = (bus.byte_data == r_csum) ? ST_DONE : ST_ERROR;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs. Outputs are loaded from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_len_hi     <= '0;
            r_count      <= '0;
            r_addr       <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_csum       <= '0;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_cpu_hold   <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= accepts_bytes(w_next);
            r_cpu_hold   <= holds_cpu(w_next);
            r_mem_we     <= (w_next == ST_WRITE);
            r_done       <= (w_next == ST_DONE);
            r_error      <= (w_next == ST_ERROR);

            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_len_hi <= '0;
                        r_count  <= '0;
                        r_addr   <= '0;
                        r_idx    <= '0;
                        r_csum   <= '0;
                    end
                end
                ST_LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= bus.byte_data;
                        r_csum   <= r_csum ^ bus.byte_data;
                    end
                end
                ST_LEN_LO: begin
                    if (w_xfer) begin
                        r_count <= w_count_rx;
                        r_csum  <= r_csum ^ bus.byte_data;
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        // MSB arrives first; the index wraps to 0 after byte 3.
                        r_shift <= {r_shift[23:0], bus.byte_data};
                        r_idx   <= r_idx + c_idx_w'(1);
                        r_csum  <= r_csum ^ bus.byte_data;
                    end
                end
                ST_WRITE: begin
                    r_addr <= r_addr + c_acc_w'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_addr[ADDR_WIDTH-1:0];
    assign bus.mem_wdata  = r_shift;
    assign cpu_hold       = r_cpu_hold;
    assign done           = r_done;
    assign error          = r_error;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_mem_loader
//  Description : Self-checking bench for inst_mem_loader. Streams are built
//                from word lists; expected writes and final status come from
//                the stream rules (header, words, XOR checksum, size limit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_loader;

    localparam int AW = 10;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic cpu_hold;
    logic done;
    logic error;

    inst_mem_loader_if #(.ADDR_WIDTH(AW)) bif();

    inst_mem_loader #(.ADDR_WIDTH(AW), .COUNT_WIDTH(16)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .bus      (bif),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t wr_log[$];

    always @(negedge clock) begin
        if (bif.mem_we === 1'b1) wr_log.push_back({bif.mem_addr, bif.mem_wdata});
    end

    // ---------------- reference model / stimulus helpers ----------------
    function automatic void make_stream(input int count, input logic [31:0] words[$],
                                        input bit corrupt, output logic [7:0] s[$]);
        logic [7:0]  x;
        logic [15:0] c;
        x = 8'h00;
        c = 16'(count);
        s = {};
        s.push_back(c[15:8]);
        s.push_back(c[7:0]);
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) s.push_back(words[i][b*8 +: 8]);
        end
        foreach (s[i]) x ^= s[i];
        if (corrupt) s.push_back((x != 8'h00) ? 8'h00 : 8'hFF);
        else         s.push_back(x);
    endfunction

    // Returns at the negedge after start has been sampled.
    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called at a negedge. mode 0: valid always, 1: every other cycle,
    // 2: random valid and random (ignored) start pulses.
    task automatic send_bytes(input logic [7:0] s[$], input int mode,
                              input int limit, output int sent);
        int idx;
        int n;
        bit v;
        idx = 0;
        n   = 0;
        while (idx < s.size() && n < limit) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (n % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (mode == 2) start = 1'($urandom_range(0, 1));
            bif.byte_valid = v;
            bif.byte_data  = v ? s[idx] : 8'($urandom);
            if (v && bif.byte_ready === 1'b1) idx++;
            @(negedge clock);
            n++;
        end
        bif.byte_valid = 1'b0;
        start          = 1'b0;
        sent           = idx;
    endtask

    task automatic wait_end(input int limit);
        int n;
        n = 0;
        while (!(done === 1'b1 || error === 1'b1) && n < limit) begin
            @(negedge clock);
            n++;
        end
    endtask

    // Full load scenario: checks consumption, final status and every write.
    task automatic test_load(input string name, input int count, input logic [31:0] words[$],
                             input bit corrupt, input int mode, output int cycles);
        logic [7:0]  s[$];
        wr_t         exp_wr[$];
        int          sent;
        int unsigned t0;
        bit          exp_done;
        make_stream(count, words, corrupt, s);
        exp_done = !corrupt;
        foreach (words[i]) exp_wr.push_back({AW'(i), words[i]});
        wr_log.delete();
        pulse_start();
        t0 = cyc;
        send_bytes(s, mode, 30000, sent);
        wait_end(50);
        cycles = int'(cyc - t0);
        n_checks++;
        if (sent !== s.size()) begin
            n_errors++;
            $display("FAIL %s bytes_consumed: got %0d expected %0d", name, sent, s.size());
        end
        n_checks++;
        if (done !== exp_done || error !== !exp_done) begin
            n_errors++;
            $display("FAIL %s status: got done=%0b error=%0b expected done=%0b error=%0b",
                     name, done, error, exp_done, !exp_done);
        end
        n_checks++;
        if (cpu_hold !== !exp_done || bif.byte_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL %s hold/ready: got hold=%0b ready=%0b expected hold=%0b ready=0",
                     name, cpu_hold, bif.byte_ready, !exp_done);
        end
        n_checks++;
        if (wr_log.size() != exp_wr.size()) begin
            n_errors++;
            $display("FAIL %s write_count: got %0d expected %0d", name, wr_log.size(), exp_wr.size());
        end
        foreach (exp_wr[i]) begin
            if (i < wr_log.size()) begin
                n_checks++;
                if (wr_log[i] !== exp_wr[i]) begin
                    n_errors++;
                    $display("FAIL %s write[%0d]: got addr=%0d data=%h expected addr=%0d data=%h",
                             name, i, wr_log[i].addr, wr_log[i].data, exp_wr[i].addr, exp_wr[i].data);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        reset_n        = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({bif.byte_ready, bif.mem_we, cpu_hold, done, error} !== 5'b0 ||
            bif.mem_addr !== '0 || bif.mem_wdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_values: got ready=%0b we=%0b hold=%0b done=%0b err=%0b addr=%0d data=%h expected all 0",
                     bif.byte_ready, bif.mem_we, cpu_hold, done, error, bif.mem_addr, bif.mem_wdata);
        end
        reset_n = 1'b1;
        bif.byte_valid = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if (bif.byte_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_no_start: got ready=%0b hold=%0b expected 0 0", bif.byte_ready, cpu_hold);
        end
        bif.byte_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] w[$];
        int cycles;
        w = {32'h20080005, 32'h01094020};
        test_load("basic", 2, w, 1'b0, 0, cycles);
        n_checks++;
        if (cycles != 13) begin
            n_errors++;
            $display("FAIL basic_latency: got %0d cycles expected 13", cycles);
        end
    endtask

    // Restarts straight from DONE with byte_valid toggling.
    task automatic test_back_to_back();
        logic [31:0] w[$];
        int cycles;
        w = {32'h20080005, 32'h01094020};
        test_load("toggle_b2b", 2, w, 1'b0, 1, cycles);
    endtask

    task automatic test_count_zero();
        logic [31:0] w[$];
        int cycles;
        w = {};
        test_load("count_zero", 0, w, 1'b0, 0, cycles);
        n_checks++;
        if (cycles != 3) begin
            n_errors++;
            $display("FAIL count_zero_latency: got %0d cycles expected 3", cycles);
        end
    endtask

    task automatic test_bad_checksum();
        logic [31:0] w[$];
        logic [7:0]  s[$];
        int cycles;
        int sent;
        w = {32'hDEADBEEF};
        test_load("bad_csum", 1, w, 1'b1, 0, cycles);
        pulse_start();
        n_checks++;
        if (error !== 1'b0 || done !== 1'b0 || bif.byte_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            n_errors++;
            $display("FAIL restart_clears_error: got err=%0b done=%0b ready=%0b hold=%0b expected 0 0 1 1",
                     error, done, bif.byte_ready, cpu_hold);
        end
        s = {8'h00, 8'h00, 8'h00};
        send_bytes(s, 0, 20, sent);
        wait_end(20);
        n_checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            n_errors++;
            $display("FAIL reload_after_error: got done=%0b err=%0b expected 1 0", done, error);
        end
    endtask

    task automatic test_overflow();
        wr_log.delete();
        pulse_start();
        bif.byte_valid = 1'b1;
        bif.byte_data  = 8'h04;
        @(negedge clock);
        bif.byte_data  = 8'h01;
        @(negedge clock);
        n_checks++;
        if (error !== 1'b1 || bif.byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_error: got err=%0b ready=%0b hold=%0b expected 1 0 1",
                     error, bif.byte_ready, cpu_hold);
        end
        for (int i = 0; i < 8; i++) begin
            bif.byte_data = 8'($urandom);
            @(negedge clock);
        end
        bif.byte_valid = 1'b0;
        n_checks++;
        if (error !== 1'b1 || done !== 1'b0 || bif.byte_ready !== 1'b0 || wr_log.size() != 0) begin
            n_errors++;
            $display("FAIL overflow_hold: got err=%0b done=%0b ready=%0b writes=%0d expected 1 0 0 0",
                     error, done, bif.byte_ready, wr_log.size());
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] w[$];
        logic [7:0]  s[$];
        logic [7:0]  part[$];
        int sent;
        int cycles;
        for (int i = 0; i < 5; i++) w.push_back($urandom);
        make_stream(5, w, 1'b0, s);
        part = s[0:15];
        wr_log.delete();
        pulse_start();
        send_bytes(part, 0, 100, sent);
        n_checks++;
        if (wr_log.size() != 3 || cpu_hold !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_load_state: got writes=%0d hold=%0b expected 3 1", wr_log.size(), cpu_hold);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bif.byte_ready, bif.mem_we, cpu_hold, done, error} !== 5'b0 ||
            bif.mem_addr !== '0 || bif.mem_wdata !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset: got ready=%0b we=%0b hold=%0b done=%0b err=%0b addr=%0d data=%h expected all 0",
                     bif.byte_ready, bif.mem_we, cpu_hold, done, error, bif.mem_addr, bif.mem_wdata);
        end
        @(negedge clock);
        reset_n = 1'b1;
        w = {};
        for (int i = 0; i < 4; i++) w.push_back($urandom);
        test_load("after_reset", 4, w, 1'b0, 2, cycles);
    endtask

    task automatic test_max_count();
        logic [31:0] w[$];
        int cycles;
        for (int i = 0; i < 1024; i++) w.push_back($urandom);
        test_load("max_count", 1024, w, 1'b0, 0, cycles);
    endtask

    task automatic test_random();
        logic [31:0] w[$];
        int cycles;
        int n;
        bit bad;
        for (int it = 0; it < 8; it++) begin
            w   = {};
            n   = $urandom_range(1, 12);
            bad = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) w.push_back($urandom);
            test_load($sformatf("random%0d", it), n, w, bad, 2, cycles);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_count_zero();
        test_bad_checksum();
        test_overflow();
        test_reset_mid_load();
        test_max_count();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
